// File: rtl/sm_addsub_pipe.sv
// Two-stage sign-magnitude adder/subtractor with valid/ready flow control,
// overflow saturate/wrap and a saturating overflow event counter.
module sm_addsub_pipe #(
  parameter int WIDTH    = 9,
  parameter bit SATURATE = 1'b1,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] inputA,
  input  logic [WIDTH-1:0] inputB,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             ovf,
  output logic [CNT_W-1:0] ovf_count,
  input  logic             cnt_clr
);
  localparam int MAG = WIDTH - 1;

  logic           s1_valid_q, s1_valid_d;
  logic [MAG-1:0] s1_mag_a_q, s1_mag_a_d;
  logic [MAG-1:0] s1_mag_b_q, s1_mag_b_d;
  logic           s1_sign_a_q, s1_sign_a_d;
  logic           s1_sign_b_q, s1_sign_b_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_out_q, s2_out_d;
  logic             s2_ovf_q, s2_ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic s2_load, s1_load;
  logic [MAG-1:0] in_mag_a, in_mag_b;
  logic           in_sign_a, in_sign_b;
  logic [MAG:0]   sum;
  logic [MAG-1:0] diff_ab, diff_ba;
  logic [MAG-1:0] res_mag;
  logic           res_sign, res_ovf;

  assign s2_load  = !s2_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load;

  // -0 collapses to +0 here; B's sign is flipped for subtraction after that
  assign in_mag_a  = inputA[MAG-1:0];
  assign in_mag_b  = inputB[MAG-1:0];
  assign in_sign_a = inputA[MAG] & (|in_mag_a);
  assign in_sign_b = (inputB[MAG] ^ op) & (|in_mag_b);

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_mag_a_d  = s1_mag_a_q;
    s1_mag_b_d  = s1_mag_b_q;
    s1_sign_a_d = s1_sign_a_q;
    s1_sign_b_d = s1_sign_b_q;
    if (s1_load) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_mag_a_d  = in_mag_a;
        s1_mag_b_d  = in_mag_b;
        s1_sign_a_d = in_sign_a;
        s1_sign_b_d = in_sign_b;
      end
    end
  end

  assign sum     = {1'b0, s1_mag_a_q} + {1'b0, s1_mag_b_q};
  assign diff_ab = s1_mag_a_q - s1_mag_b_q;
  assign diff_ba = s1_mag_b_q - s1_mag_a_q;

  always_comb begin
    res_mag  = '0;
    res_sign = 1'b0;
    res_ovf  = 1'b0;
    if (s1_sign_a_q == s1_sign_b_q) begin
      res_sign = s1_sign_a_q;
      res_ovf  = sum[MAG];
      res_mag  = sum[MAG-1:0];
      if (sum[MAG] && SATURATE) res_mag = '1;
    end else if (s1_mag_a_q >= s1_mag_b_q) begin
      res_sign = s1_sign_a_q;
      res_mag  = diff_ab;
    end else begin
      res_sign = s1_sign_b_q;
      res_mag  = diff_ba;
    end
  end

  // A zero magnitude (including a wrap to zero) is always presented as +0
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_out_d   = s2_out_q;
    s2_ovf_d   = s2_ovf_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_out_d = {res_sign & (|res_mag), res_mag};
        s2_ovf_d = res_ovf;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (s2_valid_q && out_ready && s2_ovf_q && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_mag_a_q  <= '0;
      s1_mag_b_q  <= '0;
      s1_sign_a_q <= 1'b0;
      s1_sign_b_q <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_out_q    <= '0;
      s2_ovf_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_mag_a_q  <= s1_mag_a_d;
      s1_mag_b_q  <= s1_mag_b_d;
      s1_sign_a_q <= s1_sign_a_d;
      s1_sign_b_q <= s1_sign_b_d;
      s2_valid_q  <= s2_valid_d;
      s2_out_q    <= s2_out_d;
      s2_ovf_q    <= s2_ovf_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out       = s2_out_q;
  assign ovf       = s2_ovf_q;
  assign ovf_count = cnt_q;
endmodule

// File: tb/tb_sm_addsub_pipe.sv
// Directed + random checks of sm_addsub_pipe: three instances (saturate,
// wrap, 2-bit counter) share stimulus and are compared against a signed-value model.
module tb_sm_addsub_pipe;
  logic clk = 1'b0;
  logic rst_n, in_valid, op, out_ready, cnt_clr;
  logic [8:0] inputA, inputB;

  logic in_ready_s, out_valid_s, ovf_s, in_ready_w, out_valid_w, ovf_w, in_ready_c, out_valid_c, ovf_c;
  logic [8:0] out_s, out_w, out_c;
  logic [7:0] cnt_s, cnt_w;
  logic [1:0] cnt_c;

  always #5 clk = ~clk;

  sm_addsub_pipe #(.WIDTH(9), .SATURATE(1'b1), .CNT_W(8)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .inputA(inputA), .inputB(inputB), .op(op), .out_valid(out_valid_s),
    .out_ready(out_ready), .out(out_s), .ovf(ovf_s), .ovf_count(cnt_s), .cnt_clr(cnt_clr));

  sm_addsub_pipe #(.WIDTH(9), .SATURATE(1'b0), .CNT_W(8)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
    .inputA(inputA), .inputB(inputB), .op(op), .out_valid(out_valid_w),
    .out_ready(out_ready), .out(out_w), .ovf(ovf_w), .ovf_count(cnt_w), .cnt_clr(cnt_clr));

  sm_addsub_pipe #(.WIDTH(9), .SATURATE(1'b1), .CNT_W(2)) u_cnt2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_c),
    .inputA(inputA), .inputB(inputB), .op(op), .out_valid(out_valid_c),
    .out_ready(out_ready), .out(out_c), .ovf(ovf_c), .ovf_count(cnt_c), .cnt_clr(cnt_clr));

  typedef struct {logic [8:0] s; logic [8:0] w; logic v;} exp_t;
  exp_t q[$];
  int vectors = 0, miscompares = 0, pops = 0;
  int m_cnt_s = 0, m_cnt_w = 0, m_cnt_c = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Returns {ovf, result}; works on signed values rather than bit tricks
  function automatic logic [9:0] ref_op(logic [8:0] a, logic [8:0] b, logic o, bit sat);
    int ma = int'(a[7:0]);
    int mb = int'(b[7:0]);
    int va = (a[8] ? -ma : ma);
    int vb = (b[8] ? -mb : mb);
    int r  = o ? va - vb : va + vb;
    int m  = (r < 0) ? -r : r;
    bit neg = (r < 0);
    bit v = 1'b0;
    logic [7:0] m8;
    if (m > 255) begin
      v = 1'b1;
      m = sat ? 255 : m - 256;
    end
    m8 = m[7:0];
    if (m == 0) neg = 1'b0;
    return {v, neg, m8};
  endfunction

  task automatic drive(logic v, logic [8:0] a, logic [8:0] b, logic o);
    in_valid = v; inputA = a; inputB = b; op = o;
  endtask

  task automatic tick();
    bit ix, ox;
    exp_t e;
    logic [9:0] rs, rw;
    #3;
    ix = in_valid && in_ready_s;
    ox = out_valid_s && out_ready;
    if (ox) begin
      check("scoreboard_nonempty", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        pops++;
        check("out_sat", 32'(out_s), 32'(e.s));
        check("ovf_sat", 32'(ovf_s), 32'(e.v));
        check("out_wrap", 32'(out_w), 32'(e.w));
        check("ovf_wrap", 32'(ovf_w), 32'(e.v));
        check("out_cnt2", 32'(out_c), 32'(e.s));
        if (!cnt_clr && e.v) begin
          if (m_cnt_s < 255) m_cnt_s++;
          if (m_cnt_w < 255) m_cnt_w++;
          if (m_cnt_c < 3) m_cnt_c++;
        end
      end
    end
    if (cnt_clr) begin
      m_cnt_s = 0; m_cnt_w = 0; m_cnt_c = 0;
    end
    if (ix) begin
      rs = ref_op(inputA, inputB, op, 1'b1);
      rw = ref_op(inputA, inputB, op, 1'b0);
      e.s = rs[8:0]; e.w = rw[8:0]; e.v = rs[9];
      q.push_back(e);
    end
    @(posedge clk); #1;
    check("cnt_sat", 32'(cnt_s), 32'(m_cnt_s));
    check("cnt_wrap", 32'(cnt_w), 32'(m_cnt_w));
    check("cnt_cnt2", 32'(cnt_c), 32'(m_cnt_c));
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    for (int i = 0; i < 20 && q.size() > 0; i++) tick();
    check("drain_empty", 32'(q.size()), 32'd0);
  endtask

  task automatic run_one(logic [8:0] a, logic [8:0] b, logic o,
                         logic [8:0] es, logic [8:0] ew, logic ev);
    drive(1'b1, a, b, o); tick();
    in_valid = 1'b0; tick();
    check("one_valid", 32'(out_valid_s), 32'd1);
    check("one_out_sat", 32'(out_s), 32'(es));
    check("one_out_wrap", 32'(out_w), 32'(ew));
    check("one_ovf", 32'(ovf_s), 32'(ev));
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int p0;
    logic [9:0] first;
    rst_n = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    drive(1'b0, 9'h000, 9'h000, 1'b0);
    #1;
    check("rst_out_valid", 32'(out_valid_s), 32'd0);
    check("rst_out", 32'(out_s), 32'd0);
    check("rst_ovf", 32'(ovf_s), 32'd0);
    check("rst_cnt", 32'(cnt_s), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    check("rel_in_ready", 32'(in_ready_s), 32'd1);

    // back-to-back subtraction, first result two cycles after first input
    drive(1'b1, 9'h003, 9'h002, 1'b1); tick();
    check("lat_not_yet", 32'(out_valid_s), 32'd0);
    drive(1'b1, 9'h003, 9'h102, 1'b1); tick();
    check("seq0_valid", 32'(out_valid_s), 32'd1);
    check("seq0", 32'(out_s), 32'h001);
    drive(1'b1, 9'h103, 9'h002, 1'b1); tick();
    check("seq1", 32'(out_s), 32'h005);
    drive(1'b1, 9'h103, 9'h102, 1'b1); tick();
    check("seq2", 32'(out_s), 32'h105);
    in_valid = 1'b0; tick();
    check("seq3", 32'(out_s), 32'h101);
    tick();
    check("seq_done", 32'(out_valid_s), 32'd0);

    run_one(9'h005, 9'h005, 1'b1, 9'h000, 9'h000, 1'b0);
    run_one(9'h100, 9'h100, 1'b0, 9'h000, 9'h000, 1'b0);
    run_one(9'h107, 9'h007, 1'b0, 9'h000, 9'h000, 1'b0);
    run_one(9'h0C8, 9'h064, 1'b0, 9'h0FF, 9'h02C, 1'b1);
    check("cnt_after_ovf", 32'(cnt_s), 32'd1);
    run_one(9'h180, 9'h180, 1'b0, 9'h1FF, 9'h000, 1'b1);

    // backpressure: two accepted, third stalls, first result held
    p0 = pops;
    out_ready = 1'b0;
    drive(1'b1, 9'h010, 9'h005, 1'b0);
    check("bp_rdy0", 32'(in_ready_s), 32'd1); tick();
    drive(1'b1, 9'h120, 9'h003, 1'b1);
    check("bp_rdy1", 32'(in_ready_s), 32'd1); tick();
    drive(1'b1, 9'h0F0, 9'h0F0, 1'b0);
    check("bp_rdy2", 32'(in_ready_s), 32'd0);
    first = ref_op(9'h010, 9'h005, 1'b0, 1'b1);
    repeat (5) begin
      tick();
      check("bp_stall_rdy", 32'(in_ready_s), 32'd0);
      check("bp_stall_valid", 32'(out_valid_s), 32'd1);
      check("bp_hold_out", 32'(out_s), 32'(first[8:0]));
    end
    out_ready = 1'b1; tick();
    drain();
    check("bp_count", 32'(pops - p0), 32'd3);

    // counter saturation and clear priority
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    check("clr_cnt2", 32'(cnt_c), 32'd0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 9'h0C8, 9'h064, 1'b0); tick();
    end
    drain();
    check("cnt2_sat", 32'(cnt_c), 32'd3);
    check("cnt8_five", 32'(cnt_s), 32'd5);
    drive(1'b1, 9'h0C8, 9'h064, 1'b0); tick();
    in_valid = 1'b0; tick();
    check("clr_xfer_ovf", 32'(ovf_c), 32'd1);
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    check("clr_prio_cnt2", 32'(cnt_c), 32'd0);
    check("clr_prio_cnt8", 32'(cnt_s), 32'd0);

    for (int i = 0; i < 300; i++) begin
      drive(($urandom % 4) != 0, 9'($urandom), 9'($urandom), 1'($urandom));
      out_ready = ($urandom % 4) != 0;
      cnt_clr = ($urandom % 50) == 0;
      tick();
    end
    drain();

    // asynchronous reset with both stages full
    out_ready = 1'b0;
    drive(1'b1, 9'h0C8, 9'h064, 1'b0); tick();
    drive(1'b1, 9'h050, 9'h020, 1'b0); tick();
    in_valid = 1'b0;
    check("pre_rst_valid", 32'(out_valid_s), 32'd1);
    check("pre_rst_ovf", 32'(ovf_s), 32'd1);
    check("pre_rst_full", 32'(in_ready_s), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid_s), 32'd0);
    check("arst_ovf", 32'(ovf_s), 32'd0);
    check("arst_out", 32'(out_s), 32'd0);
    check("arst_cnt", 32'(cnt_s), 32'd0);
    q.delete();
    m_cnt_s = 0; m_cnt_w = 0; m_cnt_c = 0;
    out_ready = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b1;
    check("post_rst_ready", 32'(in_ready_s), 32'd1);
    repeat (4) begin
      tick();
      check("no_stale", 32'(out_valid_s), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
